// File: rtl/q62_bcd_formatter.sv
// Sequential Q6.2 to sign-magnitude BCD converter for the calculator display path.
// Integer part via one-shift-per-clock double-dabble; fraction via a fixed quarter lookup.
module q62_bcd_formatter #(
  parameter int         INT_BITS   = 6,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] value,
  input  logic       err_in,
  output logic       busy,
  output logic       done,
  output logic       sign,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [3:0] frac_d1,
  output logic [3:0] frac_d2,
  output logic       err_flag,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(INT_BITS + 1);

  // Handshake: start is sampled only in IDLE; busy covers LOAD and SHIFT;
  // done is a one-cycle pulse in DONE with outputs already updated.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [7:0]          val_q;
  logic                neg_q;
  logic [1:0]          frac_q;
  logic [INT_BITS-1:0] int_sr;
  logic [7:0]          bcd_sr;
  logic [CW-1:0]       cnt;

  logic [8:0]          val_ext;
  logic [8:0]          mag;
  logic [3:0]          tens_adj;
  logic [3:0]          units_adj;
  logic [7:0]          bcd_nxt;
  logic [INT_BITS-1:0] int_nxt;
  logic                last_shift;
  logic                accept;

  // 9-bit negate so that -128 yields +128 rather than wrapping.
  assign val_ext = {val_q[7], val_q};
  assign mag     = val_q[7] ? (~val_ext + 9'd1) : val_ext;

  assign tens_adj  = (bcd_sr[7:4] >= 4'd5) ? (bcd_sr[7:4] + 4'd3) : bcd_sr[7:4];
  assign units_adj = (bcd_sr[3:0] >= 4'd5) ? (bcd_sr[3:0] + 4'd3) : bcd_sr[3:0];
  assign {bcd_nxt, int_nxt} = {tens_adj, units_adj, int_sr} << 1;

  assign last_shift = (state == S_SHIFT) && (cnt == CW'(1));
  assign accept     = (state == S_IDLE) && start;

  assign busy      = (state == S_LOAD) || (state == S_SHIFT);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  function automatic logic [7:0] frac_lut(input logic [1:0] q);
    logic [7:0] r;
    case (q)
      2'b00:   r = {4'd0, 4'd0};
      2'b01:   r = {4'd2, 4'd5};
      2'b10:   r = {4'd5, 4'd0};
      default: r = {4'd7, 4'd5};
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = err_in ? S_DONE : S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: if (cnt == CW'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Conversion datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= '0;
      neg_q  <= 1'b0;
      frac_q <= '0;
      int_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
    end else begin
      if (accept && !err_in) val_q <= value;
      if (state == S_LOAD) begin
        neg_q  <= val_q[7];
        frac_q <= mag[1:0];
        // Integer part tops out at 32; the clamp only guards an impossible carry.
        int_sr <= mag[8] ? '1 : mag[INT_BITS+1:2];
        bcd_sr <= '0;
        cnt    <= CW'(INT_BITS);
      end else if (state == S_SHIFT) begin
        bcd_sr <= bcd_nxt;
        int_sr <= int_nxt;
        cnt    <= cnt - CW'(1);
      end
    end
  end

  // Display registers change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign     <= 1'b0;
      tens     <= 4'h0;
      units    <= 4'h0;
      frac_d1  <= 4'h0;
      frac_d2  <= 4'h0;
      err_flag <= 1'b0;
    end else if (accept && err_in) begin
      sign     <= 1'b0;
      tens     <= BLANK_CODE;
      units    <= BLANK_CODE;
      frac_d1  <= BLANK_CODE;
      frac_d2  <= BLANK_CODE;
      err_flag <= 1'b1;
    end else if (last_shift) begin
      sign               <= neg_q;
      tens               <= bcd_nxt[7:4];
      units              <= bcd_nxt[3:0];
      {frac_d1, frac_d2} <= frac_lut(frac_q);
      err_flag           <= 1'b0;
    end
  end

endmodule

// File: tb/tb_q62_bcd_formatter.sv
// Randomized scoreboard bench for q62_bcd_formatter: driver pushes expected
// digits, latency and busy length; a negedge monitor pops and compares on done.
module tb_q62_bcd_formatter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] value = 8'h00;
  logic       err_in = 1'b0;
  logic       busy, done, sign, err_flag;
  logic [3:0] tens, units, frac_d1, frac_d2;
  logic [1:0] dbg_state;

  q62_bcd_formatter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .value     (value),
    .err_in    (err_in),
    .busy      (busy),
    .done      (done),
    .sign      (sign),
    .tens      (tens),
    .units     (units),
    .frac_d1   (frac_d1),
    .frac_d2   (frac_d2),
    .err_flag  (err_flag),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];
  int          acc_q[$];
  int          lat_q[$];
  int          busy_q[$];
  logic [17:0] last_exp = '0;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;

  wire [17:0] dut_out = {err_flag, sign, tens, units, frac_d1, frac_d2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain decimal arithmetic on quarters.
  function automatic logic [17:0] model(input logic [7:0] v, input logic e);
    int sv, mag, ip, fr;
    if (e) return {1'b1, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF};
    sv  = $signed(v);
    mag = (sv < 0) ? -sv : sv;
    ip  = mag / 4;
    fr  = (mag % 4) * 25;
    return {1'b0, (sv < 0), 4'(ip / 10), 4'(ip % 10), 4'(fr / 10), 4'(fr % 10)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [7:0] v, input logic e);
    int guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while ((busy || done) && guard < 50);
    if (guard >= 50) check("idle_timeout", 32'd1, 32'd0);
    value  = v;
    err_in = e;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(model(v, e));
    acc_q.push_back(cyc);
    lat_q.push_back(e ? 1 : 8);
    busy_q.push_back(e ? 0 : 7);
  endtask

  task automatic pulse_start_if_active(input logic [7:0] v, input logic e);
    if (busy || done) begin
      value  = v;
      err_in = e;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    lat_q.delete();
    busy_q.delete();
    last_exp = '0;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_outputs", dut_out, 18'h0);
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  int busy_run = 0;
  bit prev_done = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!rst_n) begin
          busy_run  = 0;
          prev_done = 1'b0;
          check("reset_quiet", {busy, done, dut_out}, 20'h0);
        end else begin
          if (busy) busy_run++;
          if (done) begin
            check("done_not_busy", busy, 1'b0);
            check("done_single", prev_done, 1'b0);
            if (exp_q.size() == 0) begin
              check("unexpected_done", 32'd1, 32'd0);
            end else begin
              logic [17:0] e;
              int a, l, b;
              e = exp_q.pop_front();
              a = acc_q.pop_front();
              l = lat_q.pop_front();
              b = busy_q.pop_front();
              check("result", dut_out, e);
              check("latency", cyc - a + 1, l);
              check("busy_cycles", busy_run, b);
              last_exp = e;
            end
            busy_run = 0;
          end else begin
            check("hold", dut_out, last_exp);
          end
          prev_done = done;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #1;
    mon_en = 1'b1;
    do_reset(3);

    // Directed cases.
    issue(8'h0D, 1'b0);
    issue(8'h80, 1'b0);
    issue(8'h7F, 1'b0);
    issue(8'hFF, 1'b0);
    issue(8'h40, 1'b1);
    issue(8'h00, 1'b0);

    // Re-pulse start and change value mid-conversion: must be ignored.
    issue(8'h29, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    pulse_start_if_active(8'h01, 1'b1);
    value = 8'h01;

    // start during the DONE cycle must also be ignored.
    issue(8'hB3, 1'b0);
    begin
      int g = 0;
      while (!done && g < 20) begin
        @(posedge clk); #1;
        g++;
      end
      if (g >= 20) check("done_wait_timeout", 32'd1, 32'd0);
    end
    pulse_start_if_active(8'h11, 1'b0);

    // Reset during SHIFT aborts with no done pulse.
    issue(8'h4B, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    do_reset(2);
    repeat (3) @(posedge clk);
    issue(8'h06, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] v;
      logic       e;
      int         sel;
      v = 8'($urandom_range(0, 255));
      e = ($urandom_range(0, 7) == 0);
      issue(v, e);
      value  = 8'($urandom);
      err_in = 1'($urandom);
      sel = $urandom_range(0, 2);
      if (sel == 1) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
        pulse_start_if_active(8'($urandom), 1'($urandom));
      end else if (sel == 2) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
      end
    end

    // Drain outstanding expectations.
    begin
      int g = 0;
      while (exp_q.size() > 0 && g < 100) begin
        @(posedge clk);
        g++;
      end
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/q62_bcd_formatter.md
Name: q62_bcd_formatter

Overview:
- Sequential back-end for the calculator datapath.
- Takes a signed Q6.2 ALU result plus its error flag and converts it to sign-magnitude decimal digits for the display driver.
- Integer part uses iterative double-dabble, one shift per clock. Fraction part uses a fixed 2-digit lookup (.00/.25/.50/.75).
- Uses a start/busy/done handshake, so the display layer latches a stable value only when conversion completes.

Parameters:
INT_BITS, 6, integer-part width of the Q6.2 magnitude; sets the number of double-dabble shift cycles
BLANK_CODE, 4'hF, digit code driven on all digit outputs when an error is displayed

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion of value/err_in; sampled only in IDLE
value  input  8  signed Q6.2 operand (two's complement, 2 fraction bits)
err_in  input  1  ALU error flag accompanying value
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; digit outputs valid and stable from this cycle on
sign  output  1  1 = negative result
tens  output  4  BCD tens digit of integer part
units  output  4  BCD units digit of integer part
frac_d1  output  4  BCD tenths digit
frac_d2  output  4  BCD hundredths digit
err_flag  output  1  1 = last completed request carried err_in

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy, done, sign and err_flag = 0; all digit outputs 4'h0; internal shift/BCD registers cleared.
- Reset mid-conversion aborts immediately with no done pulse. After rst_n deasserts, outputs stay at the reset values until the next completed request.
- IDLE: busy=0. If start=1 at a rising edge:
  - err_in=1: go to DONE.
  - err_in=0: capture value into an internal register and go to LOAD.
- LOAD (1 cycle):
  - Magnitude rule: magnitude = -value if value[7], else value. Use a 9-bit intermediate so -128 gives magnitude 128 (32.00), not overflow.
  - Capture neg = value[7]. A value of 0 gives sign 0; -0 does not exist.
  - Load the integer part (magnitude bits [7:2], with 128 handled as 32) into the shift register.
  - Clear the BCD accumulators, load counter = INT_BITS, go to SHIFT.
- SHIFT (INT_BITS cycles, 6 by default):
  - Each cycle, first add 3 to any BCD nibble that is 5 or more, then shift {bcd, int} left by 1.
  - Decrement the counter; at 0, go to DONE.
- DONE (1 cycle): done=1, busy=0 this cycle; next state IDLE.
  - Output registers update on the DONE entry edge, so they are already valid when done is high.
  - Normal path: sign=neg, tens/units from the BCD accumulator, err_flag=0.
  - Fraction lookup on magnitude[1:0]: 00 -> 0,0; 01 -> 2,5; 10 -> 5,0; 11 -> 7,5.
  - Error path: sign=0, tens/units/frac_d1/frac_d2 = BLANK_CODE, err_flag=1.
- busy=1 in LOAD and SHIFT only.
- Latency, normal path: done is high in the 8th cycle after the accepting edge (1 LOAD + 6 SHIFT + DONE entry).
- Latency, error path: done is high in the cycle immediately after the accepting edge.
- start while busy or in DONE is ignored, not queued. value/err_in changing during a conversion has no effect.
- Outputs hold their last completed result indefinitely between conversions. done is never asserted for two consecutive cycles.
- Integer range is 0..32, so tens never exceeds 3. No hundreds digit is needed.

Test Plan:
- value=8'h0D (3.25), err_in=0, start pulse -> done 8 cycles later; sign=0, tens=0, units=3, frac=2,5; busy high for 7 cycles.
- value=8'h80 (-128) -> sign=1, tens=3, units=2, frac=0,0, err_flag=0.
- value=8'h7F (31.75), then value=8'hFF (-0.25) back-to-back, with start reasserted on the cycle after done -> first 3,1,7,5 sign 0; second sign=1, 0,0,2,5; second done 8 cycles after second accept.
- err_in=1, value=8'h40, start -> done 1 cycle later; err_flag=1, all digits 4'hF, sign=0. A following normal value=8'h00 gives err_flag=0, all digits 0, sign=0.
- value=8'h29 (10.25) accepted, start re-pulsed and value changed to 8'h01 during SHIFT -> a single done; result 1,0,2,5 unaffected.
- rst_n pulsed low during SHIFT -> busy=0 immediately, no done pulse, outputs 0. A new start with value=8'h06 (1.50) then gives 0,1,5,0.
